// File: rtl/bus_arb_pkg.sv
// Shared types and the round-robin selection helper for the bus host arbiter.
package bus_arb_pkg;

    localparam int MAX_HOSTS = 8;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // First requester at or after prio, wrapping modulo nr_hosts; returns prio when nobody requests.
    function automatic logic [2:0] rr_next(input logic [2:0]           prio,
                                           input logic [MAX_HOSTS-1:0] req_vec,
                                           input int                   nr_hosts);
        logic [2:0] sel;
        int         idx;
        sel = prio;
        for (int k = MAX_HOSTS - 1; k >= 0; k--) begin
            idx = (int'(prio) + k) % nr_hosts;
            if (k < nr_hosts && req_vec[3'(idx)]) begin
                sel = 3'(idx);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_id_fifo.sv
// In-order queue of host indices for transactions granted but not yet answered.
module bus_id_fifo #(
    parameter int Width = 1,
    parameter int Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [Width-1:0]           push_id,
    input  logic                       pop,
    output logic [Width-1:0]           head,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one bus host port between NrHosts requesters,
// with an ID queue steering each response back to the host that issued it.
//
//   state | meaning
//   ARB   | pick the next requester round-robin and forward it to the bus
//   HOLD  | bus request pending without grant; keep forwarding held_q only
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int MaxOutstanding = 2,
    parameter int AddressWidth   = 32,
    parameter int DataWidth      = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NrHosts-1:0]                    host_req_i,
    input  logic [NrHosts-1:0]                    host_we_i,
    input  logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
    output logic [NrHosts-1:0]                    host_gnt_o,
    output logic [NrHosts-1:0]                    host_rvalid_o,
    output logic [NrHosts-1:0]                    host_err_o,
    output logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o,
    output logic                                  bus_req_o,
    output logic                                  bus_we_o,
    output logic [AddressWidth-1:0]               bus_addr_o,
    output logic [DataWidth/8-1:0]                bus_be_o,
    output logic [DataWidth-1:0]                  bus_wdata_o,
    input  logic                                  bus_gnt_i,
    input  logic                                  bus_rvalid_i,
    input  logic                                  bus_err_i,
    input  logic [DataWidth-1:0]                  bus_rdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  unexpected_rvalid_o
);
    import bus_arb_pkg::*;

    localparam int HostW = $clog2(NrHosts);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [HostW-1:0] prio_q;
    logic [HostW-1:0] held_q;
    logic [HostW-1:0] sel;
    logic [HostW-1:0] head;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;
    logic             unexpected_q;

    assign accept              = bus_req_o && bus_gnt_i;
    assign pop                 = bus_rvalid_i && !empty && !rst_i;
    assign unexpected_rvalid_o = unexpected_q;

    bus_id_fifo #(
        .Width (HostW),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (accept),
        .push_id (sel),
        .pop     (pop),
        .head    (head),
        .count   (outstanding_o),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB;
            prio_q       <= '0;
            held_q       <= '0;
            unexpected_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                prio_q <= HostW'((int'(sel) + 1) % NrHosts);
            end
            if (state_q == ARB && bus_req_o && !bus_gnt_i) begin
                held_q <= sel;
            end
            if (bus_rvalid_i && empty) begin
                unexpected_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (bus_req_o && !bus_gnt_i) state_d = HOLD;
            HOLD:    if (bus_gnt_i) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        sel = (state_q == HOLD) ? held_q
                                : HostW'(rr_next(3'(prio_q), MAX_HOSTS'(host_req_i), NrHosts));
        // A full queue blocks new requests; HOLD is never entered while full.
        bus_req_o   = !rst_i && ((state_q == HOLD) ? host_req_i[sel] : (|host_req_i && !full));
        bus_we_o    = host_we_i[sel];
        bus_addr_o  = host_addr_i[sel];
        bus_be_o    = host_be_i[sel];
        bus_wdata_o = host_wdata_i[sel];

        host_gnt_o      = '0;
        host_gnt_o[sel] = accept;

        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        if (pop) begin
            host_rvalid_o[head] = 1'b1;
            host_err_o[head]    = bus_err_i;
            host_rdata_o[head]  = bus_rdata_i;
        end
    end

    hold_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
                                      (state_q == HOLD) |-> host_req_i[held_q]);

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed bench for bus_host_arbiter with two hosts and two outstanding slots.
module tb_bus_host_arbiter;

    localparam logic [31:0] ADDR0  = 32'h0001_0000;
    localparam logic [31:0] ADDR1  = 32'h0003_0004;
    localparam logic [31:0] WDATA0 = 32'hDEAD_0000;
    localparam logic [31:0] WDATA1 = 32'hBEEF_0001;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [1:0]       host_req;
    logic [1:0]       host_we;
    logic [1:0][31:0] host_addr;
    logic [1:0][3:0]  host_be;
    logic [1:0][31:0] host_wdata;
    logic [1:0]       host_gnt;
    logic [1:0]       host_rvalid;
    logic [1:0]       host_err;
    logic [1:0][31:0] host_rdata;
    logic             bus_req;
    logic             bus_we;
    logic [31:0]      bus_addr;
    logic [3:0]       bus_be;
    logic [31:0]      bus_wdata;
    logic             bus_gnt;
    logic             bus_rvalid;
    logic             bus_err;
    logic [31:0]      bus_rdata;
    logic [1:0]       outstanding;
    logic             unexpected_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    bus_host_arbiter #(
        .NrHosts        (2),
        .MaxOutstanding (2),
        .AddressWidth   (32),
        .DataWidth      (32)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .host_req_i          (host_req),
        .host_we_i           (host_we),
        .host_addr_i         (host_addr),
        .host_be_i           (host_be),
        .host_wdata_i        (host_wdata),
        .host_gnt_o          (host_gnt),
        .host_rvalid_o       (host_rvalid),
        .host_err_o          (host_err),
        .host_rdata_o        (host_rdata),
        .bus_req_o           (bus_req),
        .bus_we_o            (bus_we),
        .bus_addr_o          (bus_addr),
        .bus_be_o            (bus_be),
        .bus_wdata_o         (bus_wdata),
        .bus_gnt_i           (bus_gnt),
        .bus_rvalid_i        (bus_rvalid),
        .bus_err_i           (bus_err),
        .bus_rdata_i         (bus_rdata),
        .outstanding_o       (outstanding),
        .unexpected_rvalid_o (unexpected_rvalid)
    );

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic        e_breq;
        logic [31:0] e_addr;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic [1:0]  e_err;
        logic [1:0]  e_outst;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] req, logic gnt, logic rv, logic err, logic [31:0] rdata,
                                logic e_breq, logic [31:0] e_addr, logic [1:0] e_gnt, logic [1:0] e_rv,
                                logic [1:0] e_err, logic [1:0] e_outst, logic [31:0] e_rd0, logic [31:0] e_rd1);
        vec_t v;
        v.req = req;  v.gnt = gnt;  v.rv = rv;  v.err = err;  v.rdata = rdata;
        v.e_breq = e_breq;  v.e_addr = e_addr;  v.e_gnt = e_gnt;  v.e_rv = e_rv;
        v.e_err = e_err;  v.e_outst = e_outst;  v.e_rd0 = e_rd0;  v.e_rd1 = e_rd1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        host_we       = 2'b01;
        host_addr[0]  = ADDR0;
        host_addr[1]  = ADDR1;
        host_be[0]    = 4'hF;
        host_be[1]    = 4'h3;
        host_wdata[0] = WDATA0;
        host_wdata[1] = WDATA1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
        bus_rdata  = '0;

        // Round-robin with rvalid one cycle after each grant
        vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,  1, ADDR0, 2'b01, 2'b00, 2'b00, 2'd0, 32'h0,  32'h0));
        vecs.push_back(mk(2'b11, 1, 1, 0, 32'hA0, 1, ADDR1, 2'b10, 2'b01, 2'b00, 2'd1, 32'hA0, 32'h0));
        vecs.push_back(mk(2'b11, 1, 1, 1, 32'hB1, 1, ADDR0, 2'b01, 2'b10, 2'b10, 2'd1, 32'h0,  32'hB1));
        vecs.push_back(mk(2'b11, 1, 1, 0, 32'hA0, 1, ADDR1, 2'b10, 2'b01, 2'b00, 2'd1, 32'hA0, 32'h0));
        vecs.push_back(mk(2'b00, 0, 1, 0, 32'hB1, 0, ADDR0, 2'b00, 2'b10, 2'b00, 2'd1, 32'h0,  32'hB1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 32'h0,  0, ADDR0, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,  32'h0));
        // Host 1 held without grant; host 0 joins but must wait
        vecs.push_back(mk(2'b10, 0, 0, 0, 32'h0,  1, ADDR1, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,  32'h0));
        vecs.push_back(mk(2'b10, 0, 0, 0, 32'h0,  1, ADDR1, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,  32'h0));
        vecs.push_back(mk(2'b11, 0, 0, 0, 32'h0,  1, ADDR1, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,  32'h0));
        vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,  1, ADDR1, 2'b10, 2'b00, 2'b00, 2'd0, 32'h0,  32'h0));
        vecs.push_back(mk(2'b01, 1, 1, 0, 32'hB1, 1, ADDR0, 2'b01, 2'b10, 2'b00, 2'd1, 32'h0,  32'hB1));
        vecs.push_back(mk(2'b00, 0, 1, 0, 32'hA0, 0, ADDR0, 2'b00, 2'b01, 2'b00, 2'd1, 32'hA0, 32'h0));
        // Fill the queue, then free one slot while host 0 waits
        vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,  1, ADDR1, 2'b10, 2'b00, 2'b00, 2'd0, 32'h0,  32'h0));
        vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,  1, ADDR0, 2'b01, 2'b00, 2'b00, 2'd1, 32'h0,  32'h0));
        vecs.push_back(mk(2'b01, 1, 0, 0, 32'h0,  0, ADDR0, 2'b00, 2'b00, 2'b00, 2'd2, 32'h0,  32'h0));
        vecs.push_back(mk(2'b01, 1, 1, 0, 32'hB1, 0, ADDR0, 2'b00, 2'b10, 2'b00, 2'd2, 32'h0,  32'hB1));
        vecs.push_back(mk(2'b01, 1, 0, 0, 32'h0,  1, ADDR0, 2'b01, 2'b00, 2'b00, 2'd1, 32'h0,  32'h0));
        vecs.push_back(mk(2'b00, 0, 1, 0, 32'hA0, 0, ADDR0, 2'b00, 2'b01, 2'b00, 2'd2, 32'hA0, 32'h0));
        vecs.push_back(mk(2'b00, 0, 1, 0, 32'hA0, 0, ADDR0, 2'b00, 2'b01, 2'b00, 2'd1, 32'hA0, 32'h0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 32'h0,  0, ADDR0, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,  32'h0));

        // Reset with requests active
        rst_i    = 1'b1;
        host_req = 2'b11;
        #1;
        chk("bus_req_in_reset", 64'(bus_req), 64'h0);
        chk("gnt_in_reset", 64'(host_gnt), 64'h0);
        repeat (2) @(negedge clk_i);
        rst_i    = 1'b0;
        host_req = 2'b00;
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'h0);
        chk("rst_gnt", 64'(host_gnt), 64'h0);
        chk("rst_rvalid", 64'(host_rvalid), 64'h0);
        chk("rst_err", 64'(host_err), 64'h0);
        chk("rst_unexpected", 64'(unexpected_rvalid), 64'h0);
        chk("rst_bus_req", 64'(bus_req), 64'h0);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            host_req   = vecs[i].req;
            bus_gnt    = vecs[i].gnt;
            bus_rvalid = vecs[i].rv;
            bus_err    = vecs[i].err;
            bus_rdata  = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_bus_req", i), 64'(bus_req), 64'(vecs[i].e_breq));
            if (vecs[i].e_breq) begin
                chk($sformatf("v%0d_bus_addr", i), 64'(bus_addr), 64'(vecs[i].e_addr));
                chk($sformatf("v%0d_bus_wdata", i), 64'(bus_wdata),
                    64'((vecs[i].e_addr == ADDR1) ? WDATA1 : WDATA0));
            end
            chk($sformatf("v%0d_host_gnt", i), 64'(host_gnt), 64'(vecs[i].e_gnt));
            chk($sformatf("v%0d_host_rvalid", i), 64'(host_rvalid), 64'(vecs[i].e_rv));
            chk($sformatf("v%0d_host_err", i), 64'(host_err), 64'(vecs[i].e_err));
            chk($sformatf("v%0d_outstanding", i), 64'(outstanding), 64'(vecs[i].e_outst));
            chk($sformatf("v%0d_rdata0", i), 64'(host_rdata[0]), 64'(vecs[i].e_rd0));
            chk($sformatf("v%0d_rdata1", i), 64'(host_rdata[1]), 64'(vecs[i].e_rd1));
        end
        chk("no_unexpected_after_table", 64'(unexpected_rvalid), 64'h0);

        // rvalid with empty queue
        @(negedge clk_i);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h55;
        #1;
        chk("empty_rv_host_rvalid", 64'(host_rvalid), 64'h0);
        chk("empty_rv_rdata0", 64'(host_rdata[0]), 64'h0);
        @(negedge clk_i);
        bus_rvalid = 1'b0;
        #1;
        chk("unexpected_set", 64'(unexpected_rvalid), 64'h1);
        repeat (10) @(negedge clk_i);
        #1;
        chk("unexpected_sticky", 64'(unexpected_rvalid), 64'h1);
        chk("empty_rv_outstanding", 64'(outstanding), 64'h0);

        // Reset with two transfers outstanding
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("unexpected_cleared", 64'(unexpected_rvalid), 64'h0);
        @(negedge clk_i);
        host_req = 2'b11;
        bus_gnt  = 1'b1;
        #1;
        chk("pre_rst_gnt0", 64'(host_gnt), 64'h1);
        @(negedge clk_i);
        #1;
        chk("pre_rst_gnt1", 64'(host_gnt), 64'h2);
        @(negedge clk_i);
        host_req = 2'b00;
        bus_gnt  = 1'b0;
        #1;
        chk("pre_rst_outstanding", 64'(outstanding), 64'h2);
        @(negedge clk_i);
        rst_i    = 1'b1;
        host_req = 2'b11;
        bus_gnt  = 1'b1;
        #1;
        chk("mid_rst_bus_req", 64'(bus_req), 64'h0);
        @(negedge clk_i);
        rst_i    = 1'b0;
        host_req = 2'b00;
        bus_gnt  = 1'b0;
        #1;
        chk("post_rst_outstanding", 64'(outstanding), 64'h0);
        chk("post_rst_gnt", 64'(host_gnt), 64'h0);
        chk("post_rst_rvalid", 64'(host_rvalid), 64'h0);
        chk("post_rst_unexpected", 64'(unexpected_rvalid), 64'h0);
        @(negedge clk_i);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hA0;
        #1;
        chk("late_rv_host_rvalid", 64'(host_rvalid), 64'h0);
        @(negedge clk_i);
        bus_rvalid = 1'b0;
        #1;
        chk("late_rv_unexpected", 64'(unexpected_rvalid), 64'h1);
        @(negedge clk_i);
        host_req = 2'b11;
        bus_gnt  = 1'b1;
        #1;
        chk("post_rst_prio0", 64'(host_gnt), 64'h1);
        @(negedge clk_i);
        host_req = 2'b00;
        bus_gnt  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
